// File: rtl/logic_issue_stage_if.sv
// logic_issue_stage_if: the two valid/ready channels of the issue stage.
//   Command channel: in_valid, in_ready, in_x, in_y, in_op.
//   Result channel:  out_valid, out_ready, out_data, out_zero.
// Modports:
//   master - the producer of commands and the consumer of results (the environment).
//   slave  - the issue stage itself.
interface logic_issue_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_x, in_y, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_x, in_y, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/logic_issue_stage.sv
// logic_issue_stage: operand issue and result buffering around a 16-bit
// combinational logic unit (AND/OR/NOT/XOR).
//   clk, rst          : single clock, synchronous active-high reset.
//   bus (slave)       : command channel in, result channel out.
//   lu_x, lu_y, lu_en : registered operands/opcode driving the logic unit.
//   lu_out            : combinational result returned by the logic unit.
//   op_count          : results written into the result FIFO, wraps.
// A command is latched in IDLE, the unit settles during the following EXEC
// cycle, and its result is written into a 2-entry FIFO at the end of EXEC.
module logic_issue_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_issue_stage_if.slave   bus,
  output logic [WIDTH-1:0]     lu_x,
  output logic [WIDTH-1:0]     lu_y,
  output logic [1:0]           lu_en,
  input  logic [WIDTH-1:0]     lu_out,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] data_mem [2];
  logic [1:0]       zero_mem;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_count;

  logic accept;
  logic push;
  logic pop;
  logic has_room;

  // Room is judged on the count before any same-edge pop, so issue never
  // depends on out_ready; EXEC then writes into a slot that is guaranteed free.
  assign has_room = (fifo_count < 2'd2);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next   = state;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = has_room;
        if (bus.in_valid && has_room) state_next = EXEC;
      end
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = (state == EXEC);
  assign pop    = bus.out_valid && bus.out_ready;

  // Outputs come straight from storage; nothing from lu_out reaches them
  // combinationally. When empty they show the stale head entry.
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = data_mem[rd_ptr];
  assign bus.out_zero  = zero_mem[rd_ptr];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. The FIFO
    // storage is reset as well, because out_data/out_zero must read 0 after
    // reset even though out_valid is low.
    if (rst) begin
      state       <= IDLE;
      lu_x        <= '0;
      lu_y        <= '0;
      lu_en       <= 2'b00;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      zero_mem    <= 2'b00;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      op_count    <= '0;
    end else begin
      state <= state_next;

      if (accept) begin
        lu_x  <= bus.in_x;
        lu_y  <= bus.in_y;
        lu_en <= bus.in_op;
      end

      if (push) begin
        data_mem[wr_ptr] <= lu_out;
        zero_mem[wr_ptr] <= (lu_out == '0);
        wr_ptr           <= ~wr_ptr;
        op_count         <= op_count + 1'b1;
      end

      if (pop) rd_ptr <= ~rd_ptr;

      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/logic_issue_stage.md
# logic_issue_stage

Operand issue and result buffering stage that sits directly around the 16-bit combinational logic unit (AND/OR/NOT/XOR). It accepts operation commands over a valid/ready handshake and registers the operands and opcode that drive the logic unit. It captures the unit's result into a 2-entry result FIFO with a zero flag and presents results downstream over a second valid/ready handshake. It also keeps a count of completed operations.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must match the logic unit.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  stage can accept a command this cycle.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y (ignored for NOT, still latched).
- in_op  in  2  opcode: 00 AND, 01 OR, 10 NOT X, 11 XOR.
- lu_x  out  WIDTH  registered operand to logic unit op_x.
- lu_y  out  WIDTH  registered operand to logic unit op_y.
- lu_en  out  2  registered opcode to logic unit op_en.
- lu_out  in  WIDTH  combinational result from logic unit op_out.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer takes head result.
- out_data  out  WIDTH  head result.
- out_zero  out  1  head result == 0.
- op_count  out  CNT_W  number of results written to FIFO, wraps.

## Operation
- FSM states: IDLE, EXEC.
- IDLE:
  - in_ready = (fifo_count < 2).
  - On in_valid & in_ready: latch in_x→lu_x, in_y→lu_y, in_op→lu_en; next state EXEC.
  - Otherwise stay in IDLE; lu_* hold their previous values.
- EXEC:
  - in_ready = 0. The logic unit settles combinationally during this cycle.
  - At the end of the cycle, write lu_out and (lu_out==0) into the FIFO tail.
  - Increment op_count, modulo 2^CNT_W.
  - Next state IDLE.
- No overflow is possible. Issue requires fifo_count<2, and during EXEC the count can only stay the same or drop before the write.
- FIFO:
  - Depth 2, pointer-based or shift-based. fifo_count ranges 0..2.
  - Pop on out_valid & out_ready.
  - A push and a pop in the same cycle leave fifo_count unchanged, and the order of results is preserved.
  - When empty, out_valid=0 and out_data/out_zero show the stale head storage.
- out_data and out_zero come directly from FIFO storage; there is no combinational path from lu_out to the out_* ports.
- in_ready is combinational from state and fifo_count only. It has no dependency on in_valid or out_ready.

## Timing
- Reset (rst=1 at an edge):
  - State → IDLE; fifo_count, pointers, storage → 0.
  - lu_x=0, lu_y=0, lu_en=2'b00, op_count=0.
  - out_valid=0, out_data=0, out_zero=0. The storage is 0, but out_zero is forced to 0 while the FIFO is empty after reset.
  - in_ready=1 in the first cycle after reset.
- Latency: command accepted at edge k → EXEC during cycle k..k+1 → FIFO write at edge k+1 → out_valid=1 from edge k+1 (one cycle accept-to-valid).
- Throughput: one command per 2 cycles maximum. in_ready is low in every EXEC cycle.
- Backpressure: with out_ready=0, at most 2 results are buffered, and in_ready stays 0 in IDLE until a pop occurs. A pop at edge j allows acceptance in the cycle after j.
- Reset during EXEC: the in-flight operation is discarded, nothing is written, and op_count is not incremented.
- op_count wraps from 2^CNT_W−1 to 0 on the next write.

## Test plan
- AND: issue x=0xF0F0, y=0x0FF0, op=00 with out_ready=1 → lu_en=00 for one cycle; out_data=0x00F0, out_zero=0, out_valid high exactly one cycle; op_count=1.
- NOT/XOR zero flag: issue NOT x=0x1234, then XOR x=y=0xA5A5 → results in order 0xEDCB (zero=0), 0x0000 (zero=1); in_ready low in each EXEC cycle; op_count=2.
- Backpressure: out_ready=0, issue OR 0x00FF|0xFF00, AND 0xFFFF&0x0001, and a third command → first two buffered (0xFFFF, 0x0001); in_ready=0 with the third command held. Raise out_ready for one cycle → 0xFFFF popped, third command accepted the next cycle, order preserved.
- Simultaneous push/pop: FIFO holds 1 entry, out_ready=1 during the EXEC write edge → fifo_count stays 1; head advances to the new result.
- Reset mid-operation: accept a command, assert rst during EXEC → no write, out_valid=0, op_count=0, lu_x=lu_y=0, lu_en=00, in_ready=1 in the next cycle.
- Counter wrap: with CNT_W=2, complete 5 operations → op_count sequence 1,2,3,0,1.
